huff_code_rx: RTL and testbench
===============================

Name: huff_code_rx

Overview:
Serial receiver placed directly downstream of the Huffman code serializer. Parses the framed bitstream (4-bit length MSB-first, then that many code bits MSB-first, valid-strobed) back into packed 13-bit code words {len[3:0], code[8:0]}. Rebuilds the 10-entry code table for the decoder and the loop-back checker.

Parameters:
NUM_SYM, 10, symbols per table (max 15)
LEN_W, 4, width of the length field
CODE_W, 9, max code bits; packed word width = LEN_W+CODE_W = 13

Ports:
Clk_in  in  1  clock, all logic on rising edge
n_Rst  in  1  reset
Start_in  in  1  sync pulse; clears table, arms receiver
Din  in  1  serial data bit
Din_vld  in  1  Din valid this cycle; idle gaps allowed anywhere
Rd_idx  in  4  table read address
Rd_code  out  13  packed code at Rd_idx; combinational read
Sym_done  out  1  one-cycle pulse, symbol complete
Sym_idx  out  4  index of completed symbol
Sym_code  out  13  packed code of completed symbol
Table_done  out  1  level; all NUM_SYM symbols received
Err  out  1  sticky; length field > CODE_W
Busy  out  1  high in LEN or BITS

Behaviour:
- Reset n_Rst asynchronous, active-low; clock Clk_in. All outputs, table entries, counters and FSM go to 0/IDLE on reset.
- FSM states: IDLE, LEN, BITS, DONE, ERR.
- IDLE: Din_vld ignored. Start_in -> LEN, sym_cnt=0, table cleared.
- LEN: each Din_vld shifts Din into len_sh (MSB first), bit_cnt++.
  - 4th bit, len==0 -> store {0,9'b0}, complete symbol, stay in LEN.
  - 4th bit, 1..9 -> BITS, bit_cnt=0.
  - 4th bit, >9 -> ERR, Err=1, no write.
- BITS: each Din_vld shifts Din into code_sh LSB (left shift), bit_cnt++. On bit_cnt==len: complete symbol.
  - code right-aligned in [8:0]; upper unused bits 0.
- Symbol complete: table[sym_cnt] written, sym_cnt++.
  - Next cycle: Sym_done=1, Sym_idx=old sym_cnt, Sym_code=word.
  - Sym_code holds until next completion.
- Last symbol (sym_cnt==NUM_SYM-1) -> DONE. Table_done=1 on the same cycle as the final Sym_done.
- DONE/ERR: Din_vld ignored. Table_done/Err hold until Start_in.
- Start_in in any state, including mid-symbol: restart as from IDLE. Clears Err, Table_done, table and shift registers. Has priority over a coincident Din_vld; that bit is dropped.
- Latency: last valid bit of a symbol -> Sym_done exactly 1 cycle.
- Rd_idx >= NUM_SYM -> Rd_code = 0.

Decomposition:
- Shared package huff_pkg: NUM_SYM, LEN_W, CODE_W, CODE_PW=13, FSM state encodings.
- The serializer uses the same package.
- One sub-module huff_code_table: NUM_SYM x 13 register file, one write port, sync clear, combinational read port.
- FSM and shifters stay in huff_code_rx.

Test Plan:
1. Start_in, then 10 symbols, each stream 0,0,1,1,1,0,1 (len 3, code 101), no gaps. Required: 10 Sym_done pulses; each Sym_code=13'b0011_000000101; Table_done on the 10th; Rd_code[0..9] match.
2. Same stream with random Din_vld gaps of 0-5 cycles. Required: identical table; Sym_done exactly 1 cycle after each symbol's last valid bit.
3. Mixed lengths:
   - len 0 -> stream 0000, word 13'h0000.
   - len 9, code 1_0110_0111 -> word {4'd9, 9'h167}.
   - len 1, code 1 -> word 13'b0001_000000001.
   - Required: Sym_idx increments 0,1,2.
4. Length field 1010 (len 10). Required: Err=1, no Sym_done, later Din_vld ignored. Start_in -> Err=0, reception resumes at idx 0.
5. Start_in after 2.5 symbols. Required: table cleared; next 10 symbols land at idx 0..9. Din_vld coincident with Start_in is dropped.
6. n_Rst low mid-BITS. Required: all outputs 0 asynchronously. Din_vld after release ignored until Start_in.

Source files
------------

// File: rtl/huff_pkg.sv
// Shared definitions for the Huffman code serializer and receiver.
// Field widths, table size and the receiver FSM encoding live here.
package huff_pkg;

  localparam int NUM_SYM = 10;
  localparam int LEN_W   = 4;
  localparam int CODE_W  = 9;
  localparam int CODE_PW = LEN_W + CODE_W;

  // Pre-sized constants so comparisons against LEN_W-bit counters stay width-clean.
  localparam logic [LEN_W-1:0] LEN_LAST = LEN_W'(LEN_W - 1);
  localparam logic [LEN_W-1:0] CODE_MAX = LEN_W'(CODE_W);
  localparam logic [LEN_W-1:0] SYM_LAST = LEN_W'(NUM_SYM - 1);

  typedef logic [CODE_PW-1:0] code_word_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_BITS,
    ST_DONE,
    ST_ERR
  } rx_state_t;

endpackage

// File: rtl/huff_code_table.sv
// NUM_SYM x CODE_PW register file: one write port, synchronous clear,
// combinational read that returns zero for out-of-range addresses.
module huff_code_table
  import huff_pkg::*;
(
  input  logic             Clk_in,
  input  logic             n_Rst,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [LEN_W-1:0] wr_addr,
  input  code_word_t       wr_data,
  input  logic [LEN_W-1:0] rd_addr,
  output code_word_t       rd_data
);

  code_word_t mem [NUM_SYM];

  // NOTE: the table is small and must read as zero straight after reset,
  // so every entry sits on the async reset rather than being left uninitialised.
  always_ff @(posedge Clk_in or negedge n_Rst) begin
    if (!n_Rst) begin
      for (int i = 0; i < NUM_SYM; i++) mem[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < NUM_SYM; i++) mem[i] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NUM_SYM; i++)
        if (wr_addr == LEN_W'(i)) mem[i] <= wr_data;
    end
  end

  // Decoded read: addresses NUM_SYM..15 never match and fall through to zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_SYM; i++)
      if (rd_addr == LEN_W'(i)) rd_data = mem[i];
  end

endmodule

// File: rtl/huff_code_rx.sv
// Serial receiver for framed Huffman codes: 4-bit length MSB-first, then that
// many code bits MSB-first. Rebuilds the code table and reports each symbol.
module huff_code_rx
  import huff_pkg::*;
(
  input  logic             Clk_in,
  input  logic             n_Rst,
  input  logic             Start_in,
  input  logic             Din,
  input  logic             Din_vld,
  input  logic [LEN_W-1:0] Rd_idx,
  output code_word_t       Rd_code,
  output logic             Sym_done,
  output logic [LEN_W-1:0] Sym_idx,
  output code_word_t       Sym_code,
  output logic             Table_done,
  output logic             Err,
  output logic             Busy
);

  rx_state_t         state;
  logic [LEN_W-1:0]  len_sh;
  logic [CODE_W-1:0] code_sh;
  logic [LEN_W-1:0]  bit_cnt;
  logic [LEN_W-1:0]  sym_cnt;

  logic [LEN_W-1:0]  len_nx;
  logic [CODE_W-1:0] code_nx;
  logic [LEN_W-1:0]  cnt_nx;
  logic              sym_cmp;
  code_word_t        sym_word;

  assign len_nx  = {len_sh[LEN_W-2:0], Din};
  assign code_nx = {code_sh[CODE_W-2:0], Din};
  assign cnt_nx  = bit_cnt + 1'b1;

  // Symbol completes on the accepting edge; a coincident Start_in wins.
  // NOTE: defaults first so every path assigns every output -- no latches.
  always_comb begin
    sym_cmp  = 1'b0;
    sym_word = '0;
    if (!Start_in && Din_vld) begin
      if (state == ST_LEN && bit_cnt == LEN_LAST && len_nx == '0) begin
        sym_cmp = 1'b1;
      end else if (state == ST_BITS && cnt_nx == len_sh) begin
        sym_cmp  = 1'b1;
        sym_word = {len_sh, code_nx};
      end
    end
  end

  huff_code_table u_table (
    .Clk_in  (Clk_in),
    .n_Rst   (n_Rst),
    .clr     (Start_in),
    .wr_en   (sym_cmp),
    .wr_addr (sym_cnt),
    .wr_data (sym_word),
    .rd_addr (Rd_idx),
    .rd_data (Rd_code)
  );

  // NOTE: all state updates use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Clk_in or negedge n_Rst) begin
    if (!n_Rst) begin
      state      <= ST_IDLE;
      len_sh     <= '0;
      code_sh    <= '0;
      bit_cnt    <= '0;
      sym_cnt    <= '0;
      Sym_done   <= 1'b0;
      Sym_idx    <= '0;
      Sym_code   <= '0;
      Table_done <= 1'b0;
      Err        <= 1'b0;
    end else begin
      Sym_done <= 1'b0;
      if (Start_in) begin
        state      <= ST_LEN;
        len_sh     <= '0;
        code_sh    <= '0;
        bit_cnt    <= '0;
        sym_cnt    <= '0;
        Table_done <= 1'b0;
        Err        <= 1'b0;
      end else if (sym_cmp) begin
        Sym_done <= 1'b1;
        Sym_idx  <= sym_cnt;
        Sym_code <= sym_word;
        sym_cnt  <= sym_cnt + 1'b1;
        bit_cnt  <= '0;
        len_sh   <= '0;
        code_sh  <= '0;
        if (sym_cnt == SYM_LAST) begin
          state      <= ST_DONE;
          Table_done <= 1'b1;
        end else begin
          state <= ST_LEN;
        end
      end else if (Din_vld) begin
        case (state)
          ST_LEN: begin
            len_sh <= len_nx;
            if (bit_cnt == LEN_LAST) begin
              bit_cnt <= '0;
              if (len_nx > CODE_MAX) begin
                state <= ST_ERR;
                Err   <= 1'b1;
              end else begin
                state   <= ST_BITS;
                code_sh <= '0;
              end
            end else begin
              bit_cnt <= cnt_nx;
            end
          end
          ST_BITS: begin
            code_sh <= code_nx;
            bit_cnt <= cnt_nx;
          end
          default: ;
        endcase
      end
    end
  end

  assign Busy = (state == ST_LEN) || (state == ST_BITS);

endmodule

// File: tb/tb_huff_code_rx.sv
// Scoreboard bench for huff_code_rx: the driver queues expected symbol reports,
// a negedge monitor pops and compares them whenever Sym_done fires.
module tb_huff_code_rx;

  logic        Clk_in = 1'b0;
  logic        n_Rst;
  logic        Start_in;
  logic        Din;
  logic        Din_vld;
  logic [3:0]  Rd_idx;
  logic [12:0] Rd_code;
  logic        Sym_done;
  logic [3:0]  Sym_idx;
  logic [12:0] Sym_code;
  logic        Table_done;
  logic        Err;
  logic        Busy;

  typedef struct {
    int          idx;
    logic [12:0] word;
    bit          tdone;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  huff_code_rx dut (
    .Clk_in     (Clk_in),
    .n_Rst      (n_Rst),
    .Start_in   (Start_in),
    .Din        (Din),
    .Din_vld    (Din_vld),
    .Rd_idx     (Rd_idx),
    .Rd_code    (Rd_code),
    .Sym_done   (Sym_done),
    .Sym_idx    (Sym_idx),
    .Sym_code   (Sym_code),
    .Table_done (Table_done),
    .Err        (Err),
    .Busy       (Busy)
  );

  always #5 Clk_in = ~Clk_in;
  always @(posedge Clk_in) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  always @(negedge Clk_in) begin
    if (n_Rst && Sym_done) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_sym_done: got idx=%0d code=0x%0h expected none", Sym_idx, Sym_code);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sym_idx", int'(Sym_idx), e.idx);
        check("sym_code", int'(Sym_code), int'(e.word));
        check("table_done_at_sym", int'(Table_done), int'(e.tdone));
        check("sym_latency_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic drive(input bit st, input bit vld, input bit d);
    Start_in = st;
    Din_vld  = vld;
    Din      = d;
    @(posedge Clk_in);
    #1;
    Start_in = 1'b0;
    Din_vld  = 1'b0;
    Din      = 1'b0;
  endtask

  task automatic send_bit(input bit d, input int gmax);
    int gap;
    gap = (gmax > 0) ? int'($urandom_range(0, gmax)) : 0;
    for (int g = 0; g < gap; g++) drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, d);
  endtask

  // Sends one framed symbol; the expectation is queued just before the last bit.
  task automatic send_sym(input int len, input logic [8:0] code, input int gmax,
                          input logic [12:0] word, input int idx, input bit tdone);
    logic [3:0] l;
    l = 4'(len);
    for (int i = 3; i >= 0; i--) begin
      if (len == 0 && i == 0) begin
        exp_t e;
        int gap;
        gap = (gmax > 0) ? int'($urandom_range(0, gmax)) : 0;
        for (int g = 0; g < gap; g++) drive(1'b0, 1'b0, 1'b0);
        e.idx = idx; e.word = word; e.tdone = tdone; e.cyc = cyc + 1;
        exp_q.push_back(e);
        drive(1'b0, 1'b1, l[i]);
      end else begin
        send_bit(l[i], gmax);
      end
    end
    for (int i = len - 1; i >= 0; i--) begin
      if (i == 0) begin
        exp_t e;
        int gap;
        gap = (gmax > 0) ? int'($urandom_range(0, gmax)) : 0;
        for (int g = 0; g < gap; g++) drive(1'b0, 1'b0, 1'b0);
        e.idx = idx; e.word = word; e.tdone = tdone; e.cyc = cyc + 1;
        exp_q.push_back(e);
        drive(1'b0, 1'b1, code[i]);
      end else begin
        send_bit(code[i], gmax);
      end
    end
  endtask

  task automatic check_rd(input string name, input int idx, input logic [12:0] word);
    Rd_idx = 4'(idx);
    #1;
    check(name, int'(Rd_code), int'(word));
  endtask

  int          mix_len  [10] = '{3, 2, 0, 9, 1, 4, 5, 1, 6, 2};
  logic [8:0]  mix_code [10] = '{9'h005, 9'h002, 9'h000, 9'h1FF, 9'h000,
                                 9'h009, 9'h016, 9'h001, 9'h038, 9'h001};
  logic [12:0] mix_word [10] = '{13'h0605, 13'h0402, 13'h0000, 13'h13FF, 13'h0200,
                                 13'h0809, 13'h0A16, 13'h0201, 13'h0C38, 13'h0401};

  initial begin
    n_Rst = 1'b0; Start_in = 1'b0; Din = 1'b0; Din_vld = 1'b0; Rd_idx = 4'd0;
    #12;
    check("rst_sym_done", int'(Sym_done), 0);
    check("rst_sym_code", int'(Sym_code), 0);
    check("rst_table_done", int'(Table_done), 0);
    check("rst_err", int'(Err), 0);
    check("rst_busy", int'(Busy), 0);
    check("rst_rd_code", int'(Rd_code), 0);
    @(posedge Clk_in); #1;
    n_Rst = 1'b1;
    drive(1'b0, 1'b1, 1'b1);
    check("idle_ignores_vld", int'(Busy), 0);

    // 1: ten identical len-3 symbols, back to back
    drive(1'b1, 1'b0, 1'b0);
    check("busy_after_start", int'(Busy), 1);
    for (int i = 0; i < 10; i++) send_sym(3, 9'h005, 0, 13'h0605, i, i == 9);
    drive(1'b0, 1'b0, 1'b0);
    check("t1_table_done", int'(Table_done), 1);
    check("t1_busy", int'(Busy), 0);
    for (int i = 0; i < 10; i++) check_rd("t1_rd_code", i, 13'h0605);
    check_rd("t1_rd_oob10", 10, 13'h0000);
    check_rd("t1_rd_oob15", 15, 13'h0000);
    for (int i = 0; i < 7; i++) drive(1'b0, 1'b1, 1'(i));
    check("done_ignores_vld", int'(Table_done), 1);

    // 2: same stream with idle gaps
    drive(1'b1, 1'b0, 1'b0);
    check("t2_table_done_cleared", int'(Table_done), 0);
    for (int i = 0; i < 10; i++) send_sym(3, 9'h005, 5, 13'h0605, i, i == 9);
    drive(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) check_rd("t2_rd_code", i, 13'h0605);

    // 3: lengths 0, 9, 1
    drive(1'b1, 1'b0, 1'b0);
    send_sym(0, 9'h000, 0, 13'h0000, 0, 1'b0);
    send_sym(9, 9'h167, 2, 13'h1367, 1, 1'b0);
    send_sym(1, 9'h001, 0, 13'h0201, 2, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    check_rd("t3_rd0", 0, 13'h0000);
    check_rd("t3_rd1", 1, 13'h1367);
    check_rd("t3_rd2", 2, 13'h0201);
    check("t3_busy", int'(Busy), 1);
    check("t3_table_done", int'(Table_done), 0);

    // 4: illegal length 10
    drive(1'b1, 1'b0, 1'b0);
    send_bit(1'b1, 0); send_bit(1'b0, 0); send_bit(1'b1, 0); send_bit(1'b0, 0);
    check("t4_err", int'(Err), 1);
    check("t4_busy", int'(Busy), 0);
    for (int i = 0; i < 12; i++) drive(1'b0, 1'b1, 1'(i >> 1));
    check("t4_err_sticky", int'(Err), 1);
    check_rd("t4_no_write", 0, 13'h0000);
    drive(1'b1, 1'b0, 1'b0);
    check("t4_err_cleared", int'(Err), 0);
    send_sym(3, 9'h005, 0, 13'h0605, 0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);

    // 5: restart after 2.5 symbols, coincident bit dropped
    drive(1'b1, 1'b0, 1'b0);
    send_sym(2, 9'h002, 0, 13'h0402, 0, 1'b0);
    send_sym(4, 9'h009, 0, 13'h0809, 1, 1'b0);
    send_bit(1'b0, 0); send_bit(1'b1, 0);
    drive(1'b1, 1'b1, 1'b1);
    check_rd("t5_cleared0", 0, 13'h0000);
    check_rd("t5_cleared1", 1, 13'h0000);
    for (int i = 0; i < 10; i++)
      send_sym(mix_len[i], mix_code[i], 1, mix_word[i], i, i == 9);
    drive(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) check_rd("t5_rd_code", i, mix_word[i]);

    // 6: async reset mid-BITS
    drive(1'b1, 1'b0, 1'b0);
    send_sym(3, 9'h005, 0, 13'h0605, 0, 1'b0);
    send_bit(1'b0, 0); send_bit(1'b1, 0); send_bit(1'b0, 0); send_bit(1'b0, 0);
    send_bit(1'b1, 0); send_bit(1'b1, 0);
    #2;
    n_Rst = 1'b0;
    #1;
    check("t6_busy", int'(Busy), 0);
    check("t6_sym_code", int'(Sym_code), 0);
    check("t6_sym_idx", int'(Sym_idx), 0);
    check("t6_sym_done", int'(Sym_done), 0);
    check_rd("t6_rd0", 0, 13'h0000);
    @(posedge Clk_in); #1;
    n_Rst = 1'b1;
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 1'(~i));
    check("t6_ignored_busy", int'(Busy), 0);
    check_rd("t6_ignored_rd0", 0, 13'h0000);
    drive(1'b1, 1'b0, 1'b0);
    send_sym(1, 9'h001, 0, 13'h0201, 0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    check_rd("t6_resume_rd0", 0, 13'h0201);

    repeat (3) drive(1'b0, 1'b0, 1'b0);
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
